// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared types and default sizing for the RAM request controller.
// cmd_t is the command word held in the command FIFO; its field widths are
// the package widths, so the RAM word/address width is changed here and the
// controller parameters follow through their defaults.
package ram_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int CMD_DEPTH_DEF  = 4;
    localparam int RSP_DEPTH_DEF  = 4;

    typedef struct packed {
        logic                      write;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } cmd_t;

    localparam int CMD_WIDTH = $bits(cmd_t);

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ram_sync_fifo.sv
// ram_sync_fifo
// Single-clock FIFO with registered count and a combinational head output.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write side; a push while full is dropped
//   pop, rdata      read side; rdata shows the head entry, pop while empty is dropped
//   full, empty     status derived from the registered count
//   count           number of stored entries (0..DEPTH)
module ram_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two and single-entry depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl
// Request-side controller in front of a single-port synchronous RAM.
// Requests are queued in a command FIFO and issued strictly in order as
// one-cycle read_en/write_en strobes. Read data is captured two edges after
// the read strobe and returned through a response buffer. Reads are issued
// only against a credit, so the response buffer can never overflow.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_write, req_addr, req_wdata    request payload
//   rsp_valid/rsp_ready, rsp_data     read response handshake, in request order
//   read_en, write_en                 registered RAM strobes, never both high
//   address_loc, data_inbit           registered RAM address / write data
//   data_outbit                       RAM read data
//   busy                              commands queued or a read in flight
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_BUS_WIDTH = ADDR_WIDTH_DEF,
    parameter int CMD_DEPTH      = CMD_DEPTH_DEF,
    parameter int RSP_DEPTH      = RSP_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      read_en,
    output logic                      write_en,
    output logic [ADDR_BUS_WIDTH-1:0] address_loc,
    output logic [DATA_WIDTH-1:0]     data_inbit,
    input  logic [DATA_WIDTH-1:0]     data_outbit,
    output logic                      busy
);

    localparam int CMD_CNT_W = cnt_width(CMD_DEPTH);
    localparam int RSP_CNT_W = cnt_width(RSP_DEPTH);

    cmd_t                  req_cmd;
    cmd_t                  head_cmd;
    logic [CMD_WIDTH-1:0]  head_bits;
    logic                  cmd_push;
    logic                  cmd_pop;
    logic                  cmd_full;
    logic                  cmd_empty;
    logic [CMD_CNT_W-1:0]  cmd_count;

    logic                  rsp_pop;
    logic                  rsp_empty;
    logic [DATA_WIDTH-1:0] rsp_head;
    logic                  rsp_full;
    logic [RSP_CNT_W-1:0]  rsp_count;
    logic                  unused_rsp_status;

    logic                      issue;
    logic                      rd_issue;
    logic                      read_en_q, read_en_d;
    logic                      write_en_q, write_en_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      rd_cap_q, rd_cap_d;
    logic [RSP_CNT_W-1:0]      credits_q, credits_d;

    assign req_cmd  = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign req_ready = !cmd_full && !rst;
    assign cmd_push  = req_valid && req_ready;
    assign head_cmd  = head_bits;

    ram_sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .wdata (req_cmd),
        .pop   (cmd_pop),
        .rdata (head_bits),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // A read head without credit blocks everything behind it, writes included.
    assign issue    = !cmd_empty && (head_cmd.write || (credits_q != '0));
    assign rd_issue = issue && !head_cmd.write;
    assign cmd_pop  = issue;

    always_comb begin
        read_en_d  = rd_issue;
        write_en_d = issue && head_cmd.write;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_cap_d   = read_en_q;
        credits_d  = credits_q;
        if (issue) begin
            addr_d = head_cmd.addr;
        end
        if (issue && head_cmd.write) begin
            wdata_d = head_cmd.wdata;
        end
        case ({rd_issue, rsp_pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_cap_q   <= 1'b0;
            credits_q  <= RSP_CNT_W'(RSP_DEPTH);
        end else begin
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_cap_q   <= rd_cap_d;
            credits_q  <= credits_d;
        end
    end

    // rd_cap_q marks the one cycle in which the RAM presents the word for the
    // read strobed two edges earlier; data_outbit is sampled nowhere else.
    assign rsp_pop = rsp_valid && rsp_ready;

    ram_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_cap_q),
        .wdata (data_outbit),
        .pop   (rsp_pop),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    // Credits already bound the buffer occupancy, so its status is not needed.
    assign unused_rsp_status = ^{rsp_full, rsp_count};

    assign rsp_valid   = !rsp_empty;
    assign rsp_data    = rsp_empty ? '0 : rsp_head;
    assign read_en     = read_en_q;
    assign write_en    = write_en_q;
    assign address_loc = addr_q;
    assign data_inbit  = wdata_q;
    assign busy        = (cmd_count != '0) || read_en_q || rd_cap_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
module tb_ram_req_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          read_en;
    logic          write_en;
    logic [AW-1:0] address_loc;
    logic [DW-1:0] data_inbit;
    logic [DW-1:0] data_outbit;
    logic          busy;

    ram_req_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .read_en     (read_en),
        .write_en    (write_en),
        .address_loc (address_loc),
        .data_inbit  (data_inbit),
        .data_outbit (data_outbit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model; a poison word is driven whenever no read is due.
    logic [DW-1:0] ram     [16];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] dout = 8'hDE;

    always @(posedge clk) begin
        if (write_en) ram[address_loc] <= data_inbit;
        if (read_en) dout <= ram[address_loc];
        else         dout <= 8'hDE;
    end
    assign data_outbit = dout;

    logic [DW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0, en_cnt = 0, pop_cnt = 0, outstanding = 0;
    int en_base = 0, pop_base = 0, rd_base = 0;
    int first_en_cyc = 0, last_en_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic          rnd_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor / scoreboard: requests enter the model when accepted, responses
    // are compared when handed over.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_prev   = 1'b0;
            outstanding = 0;
        end else begin
            chk("rd_wr_exclusive", {31'd0, read_en && write_en}, 0);
            if (read_en || write_en) begin
                if (en_cnt == en_base) first_en_cyc = cyc;
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (read_en) begin
                rd_cnt++;
                outstanding++;
                chk("credit_bound", {31'd0, outstanding <= RD}, 1);
            end
            if (hold_prev) begin
                chk("rsp_hold_valid", {31'd0, rsp_valid}, 1);
                chk("rsp_hold_data", {24'd0, rsp_data}, {24'd0, data_prev});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL rsp_unexpected: observed=%0h expected=none", rsp_data);
                end else begin
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
                end
                outstanding--;
                if (pop_cnt == pop_base) first_pop_cyc = cyc;
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            hold_prev = rsp_valid && !rsp_ready;
            data_prev = rsp_data;
            if (req_valid && req_ready) begin
                if (req_write) ref_mem[req_addr] = req_wdata;
                else           exp_q.push_back(ref_mem[req_addr]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns 1 ns after the edge at which the request was accepted.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed=ready_low expected=accept addr=%0h", a);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rsp_valid || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy || rsp_valid || (exp_q.size() != 0)}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 8'h50 + 8'(i);
            ref_mem[i] = 8'h50 + 8'(i);
        end

        // Reset state
        step(2);
        chk("reset_req_ready", {31'd0, req_ready}, 0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("reset_enables", {30'd0, read_en, write_en}, 0);
        chk("reset_ram_bus", {20'd0, address_loc, data_inbit}, 0);
        chk("reset_rsp_data", {24'd0, rsp_data}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 1);

        // Write then read same address back to back
        rsp_ready = 1'b1;
        send(1'b1, 4'd3, 8'hA5);
        send(1'b0, 4'd3, 8'h00);
        chk("t1_write_en", {31'd0, write_en}, 1);
        chk("t1_read_en_early", {31'd0, read_en}, 0);
        chk("t1_addr", {28'd0, address_loc}, 3);
        chk("t1_wdata", {24'd0, data_inbit}, 8'hA5);
        step(1);
        chk("t1_read_en", {31'd0, read_en}, 1);
        chk("t1_write_en_off", {31'd0, write_en}, 0);
        step(1);
        chk("t1_rsp_early", {31'd0, rsp_valid}, 0);
        step(1);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 1);
        chk("t1_rsp_data", {24'd0, rsp_data}, 8'hA5);
        wait_idle("t1_idle", 50);

        // Streaming writes then reads at one op per cycle
        en_base  = en_cnt;
        pop_base = pop_cnt;
        for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 8'h00);
        wait_idle("t2_idle", 100);
        chk("t2_en_count", en_cnt - en_base, 32);
        chk("t2_en_gapless", last_en_cyc - first_en_cyc, 31);
        chk("t2_pop_count", pop_cnt - pop_base, 16);
        chk("t2_pop_gapless", last_pop_cyc - first_pop_cyc, 15);

        // Credit exhaustion with consumer stalled
        rsp_ready = 1'b0;
        rd_base   = rd_cnt;
        for (int i = 0; i < 6; i++) send(1'b0, 4'(i), 8'h00);
        step(6);
        chk("t3_read_pulses", rd_cnt - rd_base, 4);
        chk("t3_rsp_valid", {31'd0, rsp_valid}, 1);
        chk("t3_rsp_head", {24'd0, rsp_data}, 8'h10);
        chk("t3_busy", {31'd0, busy}, 1);
        send(1'b0, 4'd6, 8'h00);
        send(1'b0, 4'd7, 8'h00);
        chk("t3_full_ready", {31'd0, req_ready}, 0);

        // A further request stalls while the FIFO is full
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd8;
        req_wdata = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_stall_ready", {31'd0, req_ready}, 0);
            chk("t4_stall_read_en", {31'd0, read_en}, 0);
        end
        chk("t4_no_accept", exp_q.size(), 8);
        chk("t4_reads_held", rd_cnt - rd_base, 4);
        rsp_ready = 1'b1;
        send(1'b0, 4'd8, 8'h00);
        wait_idle("t4_idle", 200);
        chk("t4_total_reads", rd_cnt - rd_base, 9);

        // Random mixed traffic against the reference memory
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                    if ($urandom_range(0, 3) == 0) step(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rsp_ready = ($urandom_range(0, 2) != 0);
                    step(1);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle("t5_idle", 300);
        chk("t5_scoreboard_empty", exp_q.size(), 0);

        // Reset in the middle of traffic
        rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(1'b0, 4'(i), 8'h00);
        step(3);
        chk("t6_busy_before", {31'd0, busy}, 1);
        chk("t6_rsp_valid_before", {31'd0, rsp_valid}, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_req_ready", {31'd0, req_ready}, 0);
        chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("t6_rst_enables", {30'd0, read_en, write_en}, 0);
        chk("t6_rst_ram_bus", {20'd0, address_loc, data_inbit}, 0);
        chk("t6_rst_rsp_data", {24'd0, rsp_data}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        #1;
        chk("t6_ready_after", {31'd0, req_ready}, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("t6_no_rsp", {31'd0, rsp_valid}, 0);
            chk("t6_idle", {31'd0, busy}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
